// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl
// Packet framer behind a UART byte receiver. Hunts for SYNC_BYTE, then
// collects LEN, LEN payload bytes and an XOR checksum (over LEN and
// payload). Verified payloads are released on a valid/ready byte stream
// with a last marker. Bad frames are discarded with a cause code.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   rx_data/rx_done/rx_error byte strobe from the UART receiver
//   pkt_data/pkt_valid/pkt_last/pkt_ready  payload drain stream
//   pkt_ok                  one-cycle pulse, verified packet drain begins
//   pkt_drop                one-cycle pulse, frame discarded
//   err_code                last drop cause: 1 csum, 2 length, 3 framing/timeout
//   ovr_count               saturating count of bytes lost during drain
//   busy                    high outside the HUNT state
module uart_rx_packet_ctrl #(
   parameter int          MAX_LEN      = 16,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int          TIMEOUT_CLKS = 52080
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       rx_error,
   output logic [7:0] pkt_data,
   output logic       pkt_valid,
   output logic       pkt_last,
   input  logic       pkt_ready,
   output logic       pkt_ok,
   output logic       pkt_drop,
   output logic [1:0] err_code,
   output logic [7:0] ovr_count,
   output logic       busy
);

   localparam int         TW        = $clog2(TIMEOUT_CLKS + 1);
   localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_HUNT,
      S_LEN,
      S_PAYLOAD,
      S_CSUM,
      S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    wr_idx_q, wr_idx_d;
   logic [7:0]    rd_idx_q, rd_idx_d;
   logic [7:0]    csum_q, csum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [1:0]    err_q, err_d;
   logic [7:0]    ovr_q, ovr_d;
   logic          ok_q, ok_d;
   logic          drop_q, drop_d;

   logic          buf_we;
   logic          do_drop;
   logic [1:0]    drop_code;
   logic          tmo_hit;
   logic [7:0]    buf_mem [MAX_LEN];

   // Timeout only matters mid-frame; a strobe in the same cycle takes priority
   // because every state below checks rx_done before tmo_hit.
   assign tmo_hit = (tmo_q == TMO_LAST);

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      csum_d    = csum_q;
      tmo_d     = '0;
      err_d     = err_q;
      ovr_d     = ovr_q;
      ok_d      = 1'b0;
      drop_d    = 1'b0;
      buf_we    = 1'b0;
      do_drop   = 1'b0;
      drop_code = 2'd0;

      case (state_q)
         S_HUNT: begin
            if (rx_done && !rx_error && rx_data == SYNC_BYTE) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_done) begin
               if (rx_error) begin
                  do_drop   = 1'b1;
                  drop_code = 2'd3;
               end else if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                  do_drop   = 1'b1;
                  drop_code = 2'd2;
               end else begin
                  len_d    = rx_data;
                  csum_d   = rx_data;
                  wr_idx_d = 8'd0;
                  state_d  = S_PAYLOAD;
               end
            end else if (tmo_hit) begin
               do_drop   = 1'b1;
               drop_code = 2'd3;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_PAYLOAD: begin
            if (rx_done) begin
               if (rx_error) begin
                  do_drop   = 1'b1;
                  drop_code = 2'd3;
               end else begin
                  buf_we   = 1'b1;
                  csum_d   = csum_q ^ rx_data;
                  wr_idx_d = wr_idx_q + 8'd1;
                  if (wr_idx_q == len_q - 8'd1) begin
                     state_d = S_CSUM;
                  end
               end
            end else if (tmo_hit) begin
               do_drop   = 1'b1;
               drop_code = 2'd3;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_CSUM: begin
            if (rx_done) begin
               if (rx_error) begin
                  do_drop   = 1'b1;
                  drop_code = 2'd3;
               end else if (rx_data == csum_q) begin
                  ok_d     = 1'b1;
                  rd_idx_d = 8'd0;
                  state_d  = S_DRAIN;
               end else begin
                  do_drop   = 1'b1;
                  drop_code = 2'd1;
               end
            end else if (tmo_hit) begin
               do_drop   = 1'b1;
               drop_code = 2'd3;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_DRAIN: begin
            // pkt_valid is always high here, so ready alone is the handshake.
            if (pkt_ready) begin
               rd_idx_d = rd_idx_q + 8'd1;
               if (rd_idx_q == len_q - 8'd1) begin
                  state_d = S_HUNT;
               end
            end
            // The framer cannot accept a new frame while draining.
            if (rx_done && ovr_q != 8'hFF) begin
               ovr_d = ovr_q + 8'd1;
            end
         end
         default: state_d = S_HUNT;
      endcase

      if (do_drop) begin
         drop_d  = 1'b1;
         err_d   = drop_code;
         state_d = S_HUNT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_HUNT;
         len_q    <= 8'd0;
         wr_idx_q <= 8'd0;
         rd_idx_q <= 8'd0;
         csum_q   <= 8'd0;
         tmo_q    <= '0;
         err_q    <= 2'd0;
         ovr_q    <= 8'd0;
         ok_q     <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         csum_q   <= csum_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
         ovr_q    <= ovr_d;
         ok_q     <= ok_d;
         drop_q   <= drop_d;
      end
   end

   // Payload buffer. Read is combinational so the first byte is presented in
   // the same cycle DRAIN is entered and the drain sustains one byte per clock.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_mem[wr_idx_q[AW-1:0]] <= rx_data;
      end
   end

   assign pkt_valid = (state_q == S_DRAIN);
   assign pkt_data  = pkt_valid ? buf_mem[rd_idx_q[AW-1:0]] : 8'h00;
   assign pkt_last  = pkt_valid && (rd_idx_q == len_q - 8'd1);
   assign pkt_ok    = ok_q;
   assign pkt_drop  = drop_q;
   assign err_code  = err_q;
   assign ovr_count = ovr_q;
   assign busy      = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Self-checking bench for uart_rx_packet_ctrl: table of frames plus hand
// sequences for timeout, framing error, backpressure/overrun and reset.
module tb_uart_rx_packet_ctrl;

   localparam int TMO = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_error;
   logic [7:0] pkt_data;
   logic       pkt_valid;
   logic       pkt_last;
   logic       pkt_ready;
   logic       pkt_ok;
   logic       pkt_drop;
   logic [1:0] err_code;
   logic [7:0] ovr_count;
   logic       busy;

   uart_rx_packet_ctrl #(
      .MAX_LEN(16),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT_CLKS(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_done(rx_done),
      .rx_error(rx_error),
      .pkt_data(pkt_data),
      .pkt_valid(pkt_valid),
      .pkt_last(pkt_last),
      .pkt_ready(pkt_ready),
      .pkt_ok(pkt_ok),
      .pkt_drop(pkt_drop),
      .err_code(err_code),
      .ovr_count(ovr_count),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] len;
      logic [7:0] seed;
      logic [7:0] stp;
      bit         bad;
      bit         stray;
      int         exp_err;   // 0 = good frame
   } vec_t;

   vec_t tbl[7];
   int   evt_q[$];    // 4 = ok pulse, 1..3 = drop with that code
   int   byte_q[$];   // {last, data}
   int   checks = 0;
   int   errors = 0;
   bit         held_v = 1'b0;
   logic [7:0] held_d;
   logic       held_l;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Checks outputs against the inputs about to be sampled on the next edge.
   task automatic mon();
      int obs;
      int ev;
      if (pkt_ok || pkt_drop) begin
         obs = (pkt_ok && pkt_drop) ? 7 : (pkt_ok ? 4 : int'(err_code));
         ev  = (evt_q.size() > 0) ? evt_q.pop_front() : -1;
         check("event", obs, ev);
      end
      if (pkt_valid) begin
         if (held_v) begin
            check("hold_data", int'(pkt_data), int'(held_d));
            check("hold_last", int'(pkt_last), int'(held_l));
         end
         if (pkt_ready) begin
            ev = (byte_q.size() > 0) ? byte_q.pop_front() : -1;
            check("drain_byte", int'({pkt_last, pkt_data}), ev);
            $display("drain byte %02h last=%0d", pkt_data, pkt_last);
            held_v = 1'b0;
         end else begin
            held_v = 1'b1;
            held_d = pkt_data;
            held_l = pkt_last;
         end
      end else begin
         held_v = 1'b0;
      end
   endtask

   task automatic step();
      mon();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic err);
      rx_data  = b;
      rx_error = err;
      rx_done  = 1'b1;
      step();
      rx_done  = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic send_frame(input vec_t v, input bit auto_drain);
      logic [7:0] cs;
      logic [7:0] b;
      int n;
      if (v.stray) begin
         send_byte(8'h5A, 1'b0);
         send_byte(8'hA5, 1'b1);
         idle(1);
      end
      send_byte(8'hA5, 1'b0);
      idle(1);
      if (v.exp_err == 2) evt_q.push_back(2);
      send_byte(v.len, 1'b0);
      if (v.exp_err != 2) begin
         cs = v.len;
         for (int k = 0; k < int'(v.len); k++) begin
            b = v.seed + 8'(k) * v.stp;
            cs = cs ^ b;
            if (v.exp_err == 0) byte_q.push_back(int'({(k == int'(v.len) - 1), b}));
            idle(1);
            send_byte(b, 1'b0);
         end
         evt_q.push_back(v.exp_err == 0 ? 4 : v.exp_err);
         idle(1);
         send_byte(v.bad ? 8'hFF : cs, 1'b0);
      end
      if (v.exp_err == 0) begin
         check("ok_pulse", int'(pkt_ok), 1);
         check("first_valid", int'(pkt_valid), 1);
         if (auto_drain) begin
            n = 0;
            while (pkt_valid && n < 300) begin
               step();
               n++;
            end
            check("drain_cycles", n, int'(v.len));
            check("busy_after", int'(busy), 0);
         end
      end else begin
         check("drop_pulse", int'(pkt_drop), 1);
         check("drop_busy", int'(busy), 0);
         check("drop_code", int'(err_code), v.exp_err);
         idle(2);
      end
      $display("frame len=%0d exp_err=%0d done", v.len, v.exp_err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   n;
      tbl[0] = '{len: 8'h03, seed: 8'h11, stp: 8'h11, bad: 0, stray: 0, exp_err: 0};
      tbl[1] = '{len: 8'h02, seed: 8'h10, stp: 8'h10, bad: 1, stray: 0, exp_err: 1};
      tbl[2] = '{len: 8'h03, seed: 8'h44, stp: 8'h01, bad: 0, stray: 0, exp_err: 0};
      tbl[3] = '{len: 8'h00, seed: 8'h00, stp: 8'h00, bad: 0, stray: 1, exp_err: 2};
      tbl[4] = '{len: 8'h11, seed: 8'h00, stp: 8'h00, bad: 0, stray: 0, exp_err: 2};
      tbl[5] = '{len: 8'h10, seed: 8'h00, stp: 8'h0F, bad: 0, stray: 0, exp_err: 0};
      tbl[6] = '{len: 8'h01, seed: 8'hFF, stp: 8'h00, bad: 0, stray: 0, exp_err: 0};

      reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rx_error = 1'b0; pkt_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", int'(pkt_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err", int'(err_code), 0);
      check("rst_ovr", int'(ovr_count), 0);
      check("rst_data", int'(pkt_data), 0);
      reset = 1'b0;
      idle(2);

      for (int i = 0; i < 7; i++) send_frame(tbl[i], 1'b1);

      // Idle timeout: drop must appear exactly TMO edges after the last strobe.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h10, 1'b0);
      evt_q.push_back(3);
      n = 0;
      while (!pkt_drop && n < 2 * TMO) begin
         step();
         n++;
      end
      check("timeout_cycles", n, TMO);
      check("timeout_code", int'(err_code), 3);
      idle(2);

      // Bytes arriving exactly at terminal count win over the timeout.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h02, 1'b0);
      byte_q.push_back(int'({1'b0, 8'h10}));
      byte_q.push_back(int'({1'b1, 8'h20}));
      idle(TMO - 1);
      send_byte(8'h10, 1'b0);
      idle(TMO - 1);
      send_byte(8'h20, 1'b0);
      evt_q.push_back(4);
      idle(TMO - 1);
      send_byte(8'h32, 1'b0);
      check("edge_ok", int'(pkt_ok), 1);
      idle(4);

      // Framing error on a payload byte.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h10, 1'b0);
      evt_q.push_back(3);
      send_byte(8'h20, 1'b1);
      check("rxerr_drop", int'(pkt_drop), 1);
      check("rxerr_code", int'(err_code), 3);
      idle(2);

      // Backpressure with overrun strobes during the drain.
      v = '{len: 8'h04, seed: 8'h21, stp: 8'h13, bad: 0, stray: 0, exp_err: 0};
      send_frame(v, 1'b0);
      n = 0;
      while (pkt_valid && n < 40) begin
         pkt_ready = n[0];
         rx_data   = 8'hA5;
         rx_done   = (n < 6) && !n[0];
         step();
         rx_done   = 1'b0;
         n++;
      end
      pkt_ready = 1'b1;
      check("bp_cycles", n, 8);
      check("ovr_count", int'(ovr_count), 3);
      idle(2);
      check("sync_lost", int'(busy), 0);

      // Reset mid-payload.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_valid", int'(pkt_valid), 0);
      check("mid_rst_err", int'(err_code), 0);
      check("mid_rst_ovr", int'(ovr_count), 0);
      check("mid_rst_drop", int'(pkt_drop), 0);
      idle(TMO + 4);
      v = '{len: 8'h01, seed: 8'h7E, stp: 8'h00, bad: 0, stray: 0, exp_err: 0};
      send_frame(v, 1'b1);
      idle(3);

      check("evt_q_empty", evt_q.size(), 0);
      check("byte_q_empty", byte_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_packet_ctrl.md
# uart_rx_packet_ctrl

Packet-level controller that sits directly behind the UART byte receiver. It consumes the receiver's byte strobe (`rx_data`/`rx_done`/`rx_error`) and hunts for a sync byte. It sequences the frame through length, payload and checksum fields, buffers the payload internally, and releases only checksum-verified packets to downstream logic over a valid/ready byte stream with a last marker. Malformed, corrupted or stalled frames are discarded and reported with a cause code.

## Interface
Parameters:
- `MAX_LEN`, default 16: maximum payload bytes per packet; legal range 1..255.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, default 52080: inter-byte timeout in clocks (≈10 bit-times at 9600 baud, 50 MHz).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte from UART receiver, valid when `rx_done`=1.
- `rx_done`  in  1  one-cycle byte-received strobe.
- `rx_error`  in  1  stop-bit/framing error qualifier for the current `rx_done`.
- `pkt_data`  out  8  payload byte at read pointer.
- `pkt_valid`  out  1  payload byte available.
- `pkt_last`  out  1  current `pkt_data` is the final payload byte.
- `pkt_ready`  in  1  downstream accepts byte when `pkt_valid`&&`pkt_ready`.
- `pkt_ok`  out  1  one-cycle pulse: packet verified, drain starting.
- `pkt_drop`  out  1  one-cycle pulse: frame discarded.
- `err_code`  out  2  cause of most recent drop: 1 checksum, 2 length, 3 framing/timeout; holds until next drop.
- `ovr_count`  out  8  saturating count of bytes lost while draining.
- `busy`  out  1  high whenever state ≠ HUNT.

## Operation
- Frame format: SYNC, LEN, LEN payload bytes, CSUM. CSUM = XOR of LEN and all payload bytes; SYNC is excluded.
- State HUNT:
  - `rx_done`&&!`rx_error`&&`rx_data`==SYNC_BYTE → LEN.
  - All other bytes, including error bytes, are ignored silently.
- State LEN, on `rx_done`:
  - `rx_error` → drop(3).
  - LEN==0 or LEN>MAX_LEN → drop(2).
  - Otherwise: latch len, csum←LEN, wr_idx←0 → PAYLOAD.
- State PAYLOAD, on `rx_done`:
  - `rx_error` → drop(3).
  - Otherwise: buf[wr_idx]←byte, csum^=byte, wr_idx++.
  - When the byte written is index len-1 → CSUM.
- State CSUM, on `rx_done`:
  - `rx_error` → drop(3).
  - byte==csum → DRAIN, `pkt_ok` pulse, rd_idx←0.
  - Otherwise → drop(1).
- Timeout:
  - In LEN/PAYLOAD/CSUM, a counter clears on state entry and on every `rx_done`, and increments otherwise.
  - When it reaches TIMEOUT_CLKS-1 with no `rx_done` that cycle → drop(3).
- drop(n): `pkt_drop`=1 for one cycle, `err_code`←n, → HUNT. The buffer is not released.
- State DRAIN:
  - `pkt_valid`=1; `pkt_data`=buf[rd_idx]; `pkt_last`=(rd_idx==len-1).
  - Each handshake advances rd_idx. The handshake with `pkt_last` → HUNT.
  - Any `rx_done` in DRAIN is discarded and increments `ovr_count`, saturating at 255. A SYNC byte arriving here is also lost.
- Widths: wr_idx, rd_idx and len are 8 bits; csum is 8 bits; the timeout counter is wide enough for TIMEOUT_CLKS.
- Reset values: `pkt_valid`, `pkt_last`, `pkt_ok`, `pkt_drop`, `busy` = 0; `err_code`=0; `ovr_count`=0; `pkt_data`=0 (don't-care outside DRAIN, driven 0); state=HUNT.

## Timing
- All state updates are registered on the `rx_done` cycle; the effect is visible the next cycle.
- `pkt_ok` and the first `pkt_valid` assert the cycle after the CSUM `rx_done`. `pkt_ok` is high only that cycle.
- `pkt_drop` asserts the cycle after the offending `rx_done` or final timeout count.
- Drain throughput is one byte per clock with `pkt_ready` held high; N-byte payload drains in N cycles.
- `pkt_data`/`pkt_last` are stable while `pkt_valid`&&!`pkt_ready`.
- `busy` drops the cycle after the last handshake or drop.
- Simultaneous `rx_done` and timeout terminal count: the byte wins, counter clears, no drop.
- `reset` mid-frame or mid-drain returns to HUNT next cycle with all outputs at reset values. No partial packet is emitted afterwards.

## Test plan
- Good frame A5 03 11 22 33 03, `pkt_ready`=1:
  - `pkt_ok` pulse, then `pkt_data` 11,22,33 on consecutive cycles.
  - `pkt_last` set only with 33; `busy` low after.
- Bad checksum A5 02 10 20 FF (correct value 32):
  - `pkt_drop`, `err_code`=1, `pkt_valid` never asserts.
  - Next good frame is accepted.
- LEN=00, then LEN=MAX_LEN+1 (17):
  - Each gives `pkt_drop` with `err_code`=2.
  - A preceding stray byte 5A is ignored; a following valid 16-byte frame drains fully with `pkt_last` on byte 16.
- A5 02 10 then idle:
  - `pkt_drop`, `err_code`=3, exactly TIMEOUT_CLKS cycles after the 10 strobe.
  - Separately, `rx_error`=1 on a payload byte gives `err_code`=3.
- Backpressure:
  - `pkt_ready` alternating 0/1 during a 4-byte drain: data order is preserved and held while stalled.
  - Three `rx_done` strobes during the drain give `ovr_count`=3.
- Reset asserted for one cycle mid-PAYLOAD:
  - All outputs return to reset values, `ovr_count`=0.
  - Next frame A5 01 7E 7F → `pkt_data` 7E with `pkt_last`.
